// File: rtl/feature_dequant_align_pkg.sv
// Shared constants, types and shift helpers for the feature de-quantisation / alignment stage.
// Widths default to the accumulator (36) and packed-feature (16) lane sizes.
package feature_dequant_align_pkg;

   localparam int MAC_OUTPUT_WIDTH_DEF = 36;
   localparam int FEATURE_WIDTH_DEF    = 16;
   localparam int FEA_LANES            = 8;
   localparam int FEA_MAX_SHIFT        = 16;
   localparam int QUANT_W              = 4;
   localparam int SHIFT_W              = 5;
   localparam int BEAT_CNT_W           = 16;

   typedef logic [QUANT_W-1:0]    quant_t;
   typedef logic [SHIFT_W-1:0]    shift_t;
   typedef logic [BEAT_CNT_W-1:0] beat_cnt_t;

   // Modular 5-bit shift: a negative difference wraps into the illegal 16..31 range.
   function automatic shift_t calc_shift(input quant_t in_q, input quant_t w_q, input quant_t out_q);
      return shift_t'({1'b0, in_q} + {1'b0, w_q} - {1'b0, out_q});
   endfunction

   function automatic logic shift_legal(input shift_t s);
      return (32'(s) < FEA_MAX_SHIFT);
   endfunction

endpackage

// File: rtl/feature_dequant_align_if.sv
// Feature-in / accumulator-out handshake bundle, including per-beat quant config and status.
// master = the side that feeds features and drains results; slave = the dequant block.
interface feature_dequant_align_if #(
   parameter int FEATURE_WIDTH    = feature_dequant_align_pkg::FEATURE_WIDTH_DEF,
   parameter int MAC_OUTPUT_WIDTH = feature_dequant_align_pkg::MAC_OUTPUT_WIDTH_DEF
);
   logic [FEATURE_WIDTH*8-1:0]    fea_data;
   logic                          fea_valid;
   logic                          fea_last;
   logic                          fea_ready;
   logic [3:0]                    fea_in_quant_size;
   logic [3:0]                    fea_out_quant_size;
   logic [3:0]                    weight_quant_size;
   logic [MAC_OUTPUT_WIDTH*8-1:0] mac_data;
   logic                          mac_valid;
   logic                          mac_last;
   logic                          mac_ready;
   logic                          quant_error;
   logic [15:0]                   beat_count;

   modport master (
      output fea_data, fea_valid, fea_last,
      output fea_in_quant_size, fea_out_quant_size, weight_quant_size,
      output mac_ready,
      input  fea_ready, mac_data, mac_valid, mac_last, quant_error, beat_count
   );

   modport slave (
      input  fea_data, fea_valid, fea_last,
      input  fea_in_quant_size, fea_out_quant_size, weight_quant_size,
      input  mac_ready,
      output fea_ready, mac_data, mac_valid, mac_last, quant_error, beat_count
   );
endinterface

// File: rtl/feature_lane_expand.sv
// One lane: sign-extend a packed feature to accumulator width and shift left by S+1.
// Illegal shifts (S >= 16) force the lane to zero and raise illegal_o.
module feature_lane_expand
   import feature_dequant_align_pkg::*;
#(
   parameter int FEATURE_WIDTH    = FEATURE_WIDTH_DEF,
   parameter int MAC_OUTPUT_WIDTH = MAC_OUTPUT_WIDTH_DEF
) (
   input  logic signed [FEATURE_WIDTH-1:0]    fea_i,
   input  shift_t                             shift_i,
   output logic signed [MAC_OUTPUT_WIDTH-1:0] lane_o,
   output logic                               illegal_o
);

   logic signed [MAC_OUTPUT_WIDTH-1:0] ext;

   assign ext       = MAC_OUTPUT_WIDTH'(fea_i);
   assign illegal_o = !shift_legal(shift_i);

   // Undoes the activate-stage truncation {sign, acc[S+1 +: FW-1]}; the dropped low bits come back as zeros.
   always_comb begin
      lane_o = '0;
      if (!illegal_o) lane_o = ext <<< ({1'b0, shift_i} + 6'd1);
   end

endmodule

// File: rtl/feature_dequant_align.sv
// Expands 8 packed features to accumulator scale through a 2-stage stallable ready/valid pipeline,
// with per-beat shift captured at accept, illegal-shift flagging and a per-frame output beat counter.
module feature_dequant_align
   import feature_dequant_align_pkg::*;
#(
   parameter int MAC_OUTPUT_WIDTH = MAC_OUTPUT_WIDTH_DEF,
   parameter int FEATURE_WIDTH    = FEATURE_WIDTH_DEF
) (
   input  logic                    system_clk,
   input  logic                    rst_n,
   feature_dequant_align_if.slave  bus
);

   localparam int FW = FEATURE_WIDTH;
   localparam int MW = MAC_OUTPUT_WIDTH;

   if (FW + FEA_MAX_SHIFT > MW) begin : g_width_chk
      $error("feature_dequant_align: FEATURE_WIDTH+16 must not exceed MAC_OUTPUT_WIDTH");
   end

   logic                    s1_vld_q, s1_vld_d;
   logic [FEA_LANES*FW-1:0] s1_data_q, s1_data_d;
   shift_t                  s1_shift_q, s1_shift_d;
   logic                    s1_last_q, s1_last_d;

   logic                    s2_vld_q, s2_vld_d;
   logic [FEA_LANES*MW-1:0] s2_data_q, s2_data_d;
   logic                    s2_last_q, s2_last_d;
   logic                    qerr_q, qerr_d;
   beat_cnt_t               bcnt_q, bcnt_d;

   logic                    advance;
   logic                    s1_load;
   logic [FEA_LANES*MW-1:0] lane_exp;
   logic [FEA_LANES-1:0]    lane_illegal;
   logic                    s1_illegal;

   assign advance       = !s2_vld_q || bus.mac_ready;
   assign s1_load       = !s1_vld_q || advance;
   assign bus.fea_ready = s1_load;

   for (genvar i = 0; i < FEA_LANES; i++) begin : g_lane
      feature_lane_expand #(
         .FEATURE_WIDTH    (FW),
         .MAC_OUTPUT_WIDTH (MW)
      ) u_expand (
         .fea_i     (s1_data_q[i*FW +: FW]),
         .shift_i   (s1_shift_q),
         .lane_o    (lane_exp[i*MW +: MW]),
         .illegal_o (lane_illegal[i])
      );
   end

   assign s1_illegal = |lane_illegal;

   always_comb begin
      s1_vld_d   = s1_vld_q;
      s1_data_d  = s1_data_q;
      s1_shift_d = s1_shift_q;
      s1_last_d  = s1_last_q;
      s2_vld_d   = s2_vld_q;
      s2_data_d  = s2_data_q;
      s2_last_d  = s2_last_q;
      qerr_d     = 1'b0;
      bcnt_d     = bcnt_q;

      // Stage 1: capture beat with the shift derived from this cycle's quant config.
      if (s1_load) begin
         s1_vld_d = bus.fea_valid;
         if (bus.fea_valid) begin
            s1_data_d  = bus.fea_data;
            s1_shift_d = calc_shift(bus.fea_in_quant_size, bus.weight_quant_size,
                                    bus.fea_out_quant_size);
            s1_last_d  = bus.fea_last;
         end
      end

      // Stage 2: expanded lanes; error pulse marks the cycle an illegal beat lands here.
      if (advance) begin
         s2_vld_d = s1_vld_q;
         if (s1_vld_q) begin
            s2_data_d = lane_exp;
            s2_last_d = s1_last_q;
            qerr_d    = s1_illegal;
         end
      end

      if (s2_vld_q && bus.mac_ready) begin
         if (s2_last_q)           bcnt_d = '0;
         else if (bcnt_q != '1)   bcnt_d = bcnt_q + beat_cnt_t'(1);
      end
   end

   always_ff @(posedge system_clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q   <= 1'b0;
         s1_data_q  <= '0;
         s1_shift_q <= '0;
         s1_last_q  <= 1'b0;
         s2_vld_q   <= 1'b0;
         s2_data_q  <= '0;
         s2_last_q  <= 1'b0;
         qerr_q     <= 1'b0;
         bcnt_q     <= '0;
      end else begin
         s1_vld_q   <= s1_vld_d;
         s1_data_q  <= s1_data_d;
         s1_shift_q <= s1_shift_d;
         s1_last_q  <= s1_last_d;
         s2_vld_q   <= s2_vld_d;
         s2_data_q  <= s2_data_d;
         s2_last_q  <= s2_last_d;
         qerr_q     <= qerr_d;
         bcnt_q     <= bcnt_d;
      end
   end

   assign bus.mac_data    = s2_data_q;
   assign bus.mac_valid   = s2_vld_q;
   assign bus.mac_last    = s2_last_q;
   assign bus.quant_error = qerr_q;
   assign bus.beat_count  = bcnt_q;

endmodule

// File: tb/tb_feature_dequant_align.sv
// Bench for feature_dequant_align: fixed vectors, randomized streams against a queue model, and reset.
module tb_feature_dequant_align;

   localparam int FW = 16;
   localparam int MW = 36;
   localparam int NL = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   feature_dequant_align_if #(.FEATURE_WIDTH(FW), .MAC_OUTPUT_WIDTH(MW)) bus ();

   feature_dequant_align #(.MAC_OUTPUT_WIDTH(MW), .FEATURE_WIDTH(FW)) dut (
      .system_clk (clk),
      .rst_n      (rst_n),
      .bus        (bus)
   );

   typedef struct {
      logic [3:0]    qi, qw, qo;
      logic [FW-1:0] f;
      logic          last;
      logic [MW-1:0] exp;
      logic          err;
   } vec_t;

   typedef struct {
      logic [NL*MW-1:0] data;
      logic             last;
      logic             err;
   } beat_t;

   int    n_chk = 0;
   int    n_fail = 0;
   int    bc = 0;
   int    nxfer = 0;
   beat_t q[$];
   bit    mon_en = 0;
   bit    acc_flag = 0;
   bit    new_beat = 1;
   vec_t  vecs[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: shift is (in + w - out) mod 32; 16..31 gives zero; otherwise value * 2^(S+1).
   function automatic int ref_shift(input logic [3:0] qi, input logic [3:0] qw, input logic [3:0] qo);
      int s;
      s = int'(qi) + int'(qw) - int'(qo);
      return ((s % 32) + 32) % 32;
   endfunction

   function automatic logic [MW-1:0] ref_lane(input logic [FW-1:0] f, input int s);
      longint v;
      if (s >= 16) return '0;
      v = longint'($signed(f));
      v = v * (longint'(1) << (s + 1));
      return v[MW-1:0];
   endfunction

   function automatic beat_t ref_beat(input logic [NL*FW-1:0] d, input logic last,
                                      input logic [3:0] qi, input logic [3:0] qw, input logic [3:0] qo);
      beat_t b;
      int s;
      s = ref_shift(qi, qw, qo);
      for (int i = 0; i < NL; i++) b.data[i*MW +: MW] = ref_lane(d[i*FW +: FW], s);
      b.last = last;
      b.err  = (s >= 16);
      return b;
   endfunction

   function automatic int bc_next(input int cur, input logic last);
      if (last) return 0;
      if (cur == 16'hFFFF) return cur;
      return cur + 1;
   endfunction

   // Observes handshakes between edges; outputs must match the queue head while valid.
   always @(negedge clk) begin
      if (mon_en) begin
         bit acc, xfer;
         acc  = bus.fea_valid && bus.fea_ready;
         xfer = bus.mac_valid && bus.mac_ready;
         chk("mon_beat_count", 64'(bus.beat_count), 64'(bc));
         if (bus.mac_valid) begin
            if (q.size() == 0) begin
               chk("mon_unexpected_beat", 64'd1, 64'd0);
            end else begin
               for (int i = 0; i < NL; i++)
                  chk($sformatf("mon_lane%0d", i), 64'(bus.mac_data[i*MW +: MW]), 64'(q[0].data[i*MW +: MW]));
               chk("mon_last", 64'(bus.mac_last), 64'(q[0].last));
               chk("mon_qerr", 64'(bus.quant_error), 64'(new_beat && q[0].err));
            end
         end else begin
            chk("mon_qerr_idle", 64'(bus.quant_error), 64'd0);
         end
         if (xfer && q.size() > 0) begin
            bc = bc_next(bc, q[0].last);
            void'(q.pop_front());
            nxfer++;
         end
         if (acc)
            q.push_back(ref_beat(bus.fea_data, bus.fea_last, bus.fea_in_quant_size,
                                 bus.weight_quant_size, bus.fea_out_quant_size));
         acc_flag = acc;
         new_beat = !bus.mac_valid || xfer;
      end
   end

   task automatic run_vec(input vec_t v, input int idx);
      logic [NL*FW-1:0] d;
      beat_t            b;
      d = {$urandom, $urandom, $urandom, $urandom};
      d[FW-1:0] = v.f;
      b = ref_beat(d, v.last, v.qi, v.qw, v.qo);
      @(posedge clk); #1;
      bus.fea_in_quant_size  = v.qi;
      bus.weight_quant_size  = v.qw;
      bus.fea_out_quant_size = v.qo;
      bus.fea_data  = d;
      bus.fea_last  = v.last;
      bus.fea_valid = 1'b1;
      bus.mac_ready = 1'b1;
      chk($sformatf("v%0d_ready", idx), 64'(bus.fea_ready), 64'd1);
      @(posedge clk); #1;
      bus.fea_valid = 1'b0;
      bus.fea_in_quant_size  = 4'($urandom);
      bus.weight_quant_size  = 4'($urandom);
      bus.fea_out_quant_size = 4'($urandom);
      chk($sformatf("v%0d_valid_n1", idx), 64'(bus.mac_valid), 64'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid_n2", idx), 64'(bus.mac_valid), 64'd1);
      chk($sformatf("v%0d_lane0", idx), 64'(bus.mac_data[MW-1:0]), 64'(v.exp));
      for (int i = 1; i < NL; i++)
         chk($sformatf("v%0d_lane%0d", idx, i), 64'(bus.mac_data[i*MW +: MW]), 64'(b.data[i*MW +: MW]));
      chk($sformatf("v%0d_last", idx), 64'(bus.mac_last), 64'(v.last));
      chk($sformatf("v%0d_qerr", idx), 64'(bus.quant_error), 64'(v.err));
      chk($sformatf("v%0d_bc_pre", idx), 64'(bus.beat_count), 64'(bc));
      @(posedge clk); #1;
      bc = bc_next(bc, v.last);
      chk($sformatf("v%0d_bc_post", idx), 64'(bus.beat_count), 64'(bc));
      chk($sformatf("v%0d_valid_after", idx), 64'(bus.mac_valid), 64'd0);
      chk($sformatf("v%0d_qerr_after", idx), 64'(bus.quant_error), 64'd0);
   endtask

   task automatic stream(input int nbeats, input bit vary, input bit last_on_final, input string tag);
      int sent = 0;
      int cyc  = 0;
      bus.fea_valid = 1'b0;
      bus.fea_in_quant_size  = 4'd3;
      bus.weight_quant_size  = 4'd4;
      bus.fea_out_quant_size = 4'd2;
      nxfer    = 0;
      new_beat = 1;
      acc_flag = 0;
      @(posedge clk); #1;
      mon_en = 1;
      while (sent < nbeats && cyc < 2000) begin
         @(posedge clk); #1;
         cyc++;
         if (bus.fea_valid && acc_flag) begin
            sent++;
            bus.fea_valid = 1'b0;
         end
         bus.mac_ready = 1'($urandom_range(0, 1));
         if (vary) begin
            bus.fea_in_quant_size  = 4'($urandom);
            bus.weight_quant_size  = 4'($urandom);
            bus.fea_out_quant_size = 4'($urandom);
         end
         if (!bus.fea_valid && sent < nbeats && $urandom_range(0, 3) != 0) begin
            bus.fea_valid = 1'b1;
            bus.fea_data  = {$urandom, $urandom, $urandom, $urandom};
            bus.fea_last  = last_on_final ? (sent == nbeats - 1) : ($urandom_range(0, 4) == 0);
         end
      end
      chk({tag, "_sent"}, 64'(sent), 64'(nbeats));
      while (q.size() > 0 && cyc < 4000) begin
         @(posedge clk); #1;
         cyc++;
         bus.mac_ready = 1'($urandom_range(0, 1));
      end
      chk({tag, "_drain"}, 64'(q.size()), 64'd0);
      chk({tag, "_xfers"}, 64'(nxfer), 64'(nbeats));
      bus.mac_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 mon_en = 0;
   endtask

   initial begin
      bus.fea_data = '0;
      bus.fea_valid = 1'b0;
      bus.fea_last = 1'b0;
      bus.fea_in_quant_size = '0;
      bus.fea_out_quant_size = '0;
      bus.weight_quant_size = '0;
      bus.mac_ready = 1'b1;

      //            qi     qw     qo     f          last  exp               err
      vecs[0] = '{4'd5,  4'd6,  4'd4,  16'h0003, 1'b0, 36'h000000300, 1'b0};
      vecs[1] = '{4'd5,  4'd6,  4'd4,  16'hFFFF, 1'b1, 36'hFFFFFFF00, 1'b0};
      vecs[2] = '{4'd0,  4'd0,  4'd0,  16'h7FFF, 1'b0, 36'h00000FFFE, 1'b0};
      vecs[3] = '{4'd15, 4'd0,  4'd0,  16'h8000, 1'b0, 36'hF80000000, 1'b0};
      vecs[4] = '{4'd0,  4'd0,  4'd1,  16'h1234, 1'b0, 36'h000000000, 1'b1};
      vecs[5] = '{4'd8,  4'd8,  4'd0,  16'h0001, 1'b1, 36'h000000000, 1'b1};
      vecs[6] = '{4'd10, 4'd10, 4'd5,  16'h0001, 1'b0, 36'h000010000, 1'b0};
      vecs[7] = '{4'd3,  4'd2,  4'd5,  16'hFFFF, 1'b0, 36'hFFFFFFFFE, 1'b0};

      #2;
      chk("rst_mac_valid", 64'(bus.mac_valid), 64'd0);
      chk("rst_mac_data0", 64'(bus.mac_data[MW-1:0]), 64'd0);
      chk("rst_beat_count", 64'(bus.beat_count), 64'd0);
      chk("rst_qerr", 64'(bus.quant_error), 64'd0);
      #20 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_fea_ready", 64'(bus.fea_ready), 64'd1);

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // Two beats in flight under backpressure, then asynchronous reset mid-cycle.
      @(posedge clk); #1;
      bus.mac_ready = 1'b0;
      bus.fea_data  = {8{16'h0101}};
      bus.fea_last  = 1'b0;
      bus.fea_valid = 1'b1;
      @(posedge clk); #1;
      bus.fea_data  = {8{16'h0202}};
      @(posedge clk); #1;
      bus.fea_valid = 1'b0;
      chk("inflight_valid", 64'(bus.mac_valid), 64'd1);
      chk("inflight_ready", 64'(bus.fea_ready), 64'd0);
      chk("inflight_bc", 64'(bus.beat_count), 64'(bc));
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_valid", 64'(bus.mac_valid), 64'd0);
      chk("midrst_data", 64'(bus.mac_data[MW-1:0]), 64'd0);
      chk("midrst_last", 64'(bus.mac_last), 64'd0);
      chk("midrst_bc", 64'(bus.beat_count), 64'd0);
      bc = 0;
      @(negedge clk);
      rst_n = 1'b1;
      bus.mac_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk($sformatf("postrst_valid%0d", i), 64'(bus.mac_valid), 64'd0);
         chk($sformatf("postrst_ready%0d", i), 64'(bus.fea_ready), 64'd1);
      end

      stream(10, 1'b0, 1'b1, "stream10");
      chk("stream10_bc_zero", 64'(bus.beat_count), 64'd0);
      stream(40, 1'b1, 1'b0, "stream_cfg");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
